// File: rtl/brick_hit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : brick_hit_ctrl
//  Description : Brick-state memory sequencer. Fills the brick grid at level
//                start and resolves ball collision queries against the
//                single-port brick RAM: on a hit it clears the brick, bumps
//                the score and reports the brick's top-left pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module brick_hit_ctrl #(
  parameter int GRIDX  = 16,
  parameter int GRIDY  = 8,
  parameter int BRICKX = 8,
  parameter int BRICKY = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        init_start,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_x,
  input  logic [9:0]  req_y,
  output logic [9:0]  mem_addr,
  output logic        mem_we,
  output logic        mem_wdata,
  input  logic        mem_rdata,
  output logic        hit_valid,
  output logic        hit,
  output logic [9:0]  hit_x,
  output logic [9:0]  hit_y,
  output logic [15:0] score,
  output logic [9:0]  bricks_left,
  output logic        all_clear
);

  localparam logic [9:0] GX         = 10'(GRIDX);
  localparam logic [9:0] GY         = 10'(GRIDY);
  localparam logic [9:0] BX         = 10'(BRICKX);
  localparam logic [9:0] BY         = 10'(BRICKY);
  localparam logic [9:0] NUM_BRICKS = 10'(GRIDX * GRIDY);
  localparam logic [9:0] LAST_ADDR  = NUM_BRICKS - 10'd1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_LOOKUP = 3'd2,
    S_CHECK  = 3'd3,
    S_CLEAR  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      state_q;
  logic [9:0]  cnt_q;
  logic [9:0]  mem_addr_q;
  logic        mem_we_q;
  logic        mem_wdata_q;
  logic        hit_valid_q;
  logic        hit_q;
  logic [9:0]  hit_x_q;
  logic [9:0]  hit_y_q;
  logic [15:0] score_q;
  logic [9:0]  left_q;
  logic        all_clear_q;

  logic [9:0]  col_d;
  logic [9:0]  row_d;
  logic [9:0]  addr_d;
  logic [9:0]  hx_d;
  logic [9:0]  hy_d;
  logic        oob_d;
  logic [15:0] score_d;
  logic [9:0]  left_d;

  // Pixel-to-grid translation of the incoming query, plus saturating counters
  always_comb begin
    col_d   = req_x / BX;
    row_d   = req_y / BY;
    addr_d  = col_d + row_d * GX;
    hx_d    = col_d * BX;
    hy_d    = row_d * BY;
    oob_d   = (col_d >= GX) || (row_d >= GY);
    score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
    left_d  = (left_q == 10'd0) ? 10'd0 : left_q - 10'd1;
  end

  // Ready only in an idle cycle with no fill pending; held low during reset
  assign req_ready = resetn && (state_q == S_IDLE) && !init_start;

  // Main sequencer; every output is registered and set on entry to its state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 10'd0;
      mem_addr_q  <= 10'd0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 1'b0;
      hit_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      hit_x_q     <= 10'd0;
      hit_y_q     <= 10'd0;
      score_q     <= 16'd0;
      left_q      <= 10'd0;
      all_clear_q <= 1'b1;
    end else begin
      hit_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (init_start) begin
            state_q     <= S_INIT;
            cnt_q       <= 10'd0;
            mem_addr_q  <= 10'd0;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= 1'b1;
          end else if (req_valid) begin
            hit_x_q <= hx_d;
            hit_y_q <= hy_d;
            hit_q   <= 1'b0;
            if (oob_d) begin
              // Outside the brick field: answer immediately, no RAM access
              state_q     <= S_DONE;
              hit_valid_q <= 1'b1;
            end else begin
              state_q    <= S_LOOKUP;
              mem_addr_q <= addr_d;
              mem_we_q   <= 1'b0;
            end
          end
        end
        S_INIT: begin
          if (cnt_q == LAST_ADDR) begin
            state_q     <= S_IDLE;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 1'b0;
            left_q      <= NUM_BRICKS;
            all_clear_q <= (NUM_BRICKS == 10'd0);
          end else begin
            cnt_q      <= cnt_q + 10'd1;
            mem_addr_q <= cnt_q + 10'd1;
          end
        end
        S_LOOKUP: begin
          // Address is already on the bus; read data arrives next cycle
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (mem_rdata) begin
            state_q     <= S_CLEAR;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= 1'b0;
          end else begin
            state_q     <= S_DONE;
            hit_valid_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          state_q     <= S_DONE;
          mem_we_q    <= 1'b0;
          score_q     <= score_d;
          left_q      <= left_d;
          all_clear_q <= (left_d == 10'd0);
          hit_q       <= 1'b1;
          hit_valid_q <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign hit_valid   = hit_valid_q;
  assign hit         = hit_q;
  assign hit_x       = hit_x_q;
  assign hit_y       = hit_y_q;
  assign score       = score_q;
  assign bricks_left = left_q;
  assign all_clear   = all_clear_q;

endmodule
`default_nettype wire

// File: tb/tb_brick_hit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_brick_hit_ctrl
//  Description : Directed self-checking bench for brick_hit_ctrl with a
//                behavioural 1-cycle-latency brick RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_brick_hit_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        init_start = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_x = 10'd0;
  logic [9:0]  req_y = 10'd0;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic        mem_wdata;
  logic        mem_rdata = 1'b0;
  logic        hit_valid;
  logic        hit;
  logic [9:0]  hit_x;
  logic [9:0]  hit_y;
  logic [15:0] score;
  logic [9:0]  bricks_left;
  logic        all_clear;

  logic        ram [0:1023];
  int          wr_cnt = 0;
  int          n_pass = 0;
  int          n_total = 0;

  brick_hit_ctrl #(.GRIDX(16), .GRIDY(8), .BRICKX(8), .BRICKY(4)) dut (
    .clk(clk), .resetn(resetn), .init_start(init_start),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .hit_valid(hit_valid), .hit(hit), .hit_x(hit_x), .hit_y(hit_y),
    .score(score), .bricks_left(bricks_left), .all_clear(all_clear)
  );

  always #5 clk = ~clk;

  // Synchronous single-port brick RAM, read data one cycle after address
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Issue one query from a negedge; returns at the negedge where hit_valid is seen
  task automatic do_query(input logic [9:0] x, input logic [9:0] y,
                          output logic rdy, output int lat, output int we_cyc,
                          output logic [9:0] we_a, output logic we_d);
    req_x = x; req_y = y; req_valid = 1'b1;
    #1 rdy = req_ready;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; we_cyc = -1; we_a = 10'd0; we_d = 1'b0;
    while (!hit_valid && lat < 20) begin
      if (mem_we && we_cyc < 0) begin we_cyc = lat; we_a = mem_addr; we_d = mem_wdata; end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_total++; if (req_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", req_ready); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL reset_we got=%b exp=0", mem_we); else n_pass++;
    n_total++; if ({score, bricks_left, all_clear, hit_valid, hit} !== {16'd0, 10'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_outs got=%h/%0d/%b/%b/%b exp=0/0/1/0/0", score, bricks_left, all_clear, hit_valid, hit); else n_pass++;
    resetn = 1'b1;
    @(negedge clk);
    n_total++; if (req_ready !== 1'b1) $display("FAIL ready_after_reset got=%b exp=1", req_ready); else n_pass++;
  endtask

  task automatic test_fill;
    int bad, ones, w0;
    bad = 0; ones = 0; w0 = wr_cnt;
    init_start = 1'b1;
    #1;
    n_total++; if (req_ready !== 1'b0) $display("FAIL fill_ready got=%b exp=0", req_ready); else n_pass++;
    @(negedge clk);
    init_start = 1'b0;
    for (int i = 0; i < 128; i++) begin
      if (mem_we !== 1'b1 || mem_wdata !== 1'b1 || mem_addr !== 10'(i)) bad++;
      @(negedge clk);
    end
    n_total++; if (bad != 0) $display("FAIL fill_seq got=%0d bad cycles exp=0", bad); else n_pass++;
    n_total++; if (wr_cnt - w0 != 128) $display("FAIL fill_writes got=%0d exp=128", wr_cnt - w0); else n_pass++;
    for (int i = 0; i < 128; i++) if (ram[i] === 1'b1) ones++;
    n_total++; if (ones != 128) $display("FAIL fill_ram got=%0d exp=128", ones); else n_pass++;
    n_total++; if ({req_ready, mem_we, bricks_left, all_clear} !== {1'b1, 1'b0, 10'd128, 1'b0})
      $display("FAIL fill_end got=%b/%b/%0d/%b exp=1/0/128/0", req_ready, mem_we, bricks_left, all_clear); else n_pass++;
  endtask

  task automatic test_hit;
    logic rdy, wd; int lat, wc; logic [9:0] wa;
    do_query(10'd20, 10'd9, rdy, lat, wc, wa, wd);
    n_total++; if (rdy !== 1'b1) $display("FAIL hit_accept got=%b exp=1", rdy); else n_pass++;
    n_total++; if (lat != 4) $display("FAIL hit_latency got=%0d exp=4", lat); else n_pass++;
    n_total++; if ({hit, hit_x, hit_y} !== {1'b1, 10'd16, 10'd8})
      $display("FAIL hit_resp got=%b/%0d/%0d exp=1/16/8", hit, hit_x, hit_y); else n_pass++;
    n_total++; if (score !== 16'd1 || bricks_left !== 10'd127)
      $display("FAIL hit_counts got=%0d/%0d exp=1/127", score, bricks_left); else n_pass++;
    n_total++; if (wc != 3 || wa !== 10'd34 || wd !== 1'b0)
      $display("FAIL hit_write got=cyc%0d addr%0d d%b exp=cyc3 addr34 d0", wc, wa, wd); else n_pass++;
    @(negedge clk);
    n_total++; if ({hit_valid, req_ready, hit, hit_x} !== {1'b0, 1'b1, 1'b1, 10'd16})
      $display("FAIL hit_after got=%b/%b/%b/%0d exp=0/1/1/16", hit_valid, req_ready, hit, hit_x); else n_pass++;
  endtask

  task automatic test_miss;
    logic rdy, wd; int lat, wc; logic [9:0] wa;
    do_query(10'd20, 10'd9, rdy, lat, wc, wa, wd);
    n_total++; if (lat != 3) $display("FAIL miss_latency got=%0d exp=3", lat); else n_pass++;
    n_total++; if (hit !== 1'b0 || score !== 16'd1 || wc != -1)
      $display("FAIL miss_resp got=hit%b score%0d we%0d exp=hit0 score1 we-1", hit, score, wc); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_out_of_grid;
    logic rdy, wd; int lat, wc; logic [9:0] wa;
    do_query(10'd50, 10'd200, rdy, lat, wc, wa, wd);
    n_total++; if (lat != 1) $display("FAIL oob_latency got=%0d exp=1", lat); else n_pass++;
    n_total++; if ({hit, hit_x, hit_y} !== {1'b0, 10'd48, 10'd200} || wc != -1 || mem_we !== 1'b0)
      $display("FAIL oob_resp got=%b/%0d/%0d we%0d exp=0/48/200 we-1", hit, hit_x, hit_y, wc); else n_pass++;
    n_total++; if (bricks_left !== 10'd127) $display("FAIL oob_left got=%0d exp=127", bricks_left); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_init_priority_and_reset;
    int w0, w1;
    init_start = 1'b1; req_valid = 1'b1; req_x = 10'd20; req_y = 10'd9;
    #1;
    n_total++; if (req_ready !== 1'b0) $display("FAIL prio_ready got=%b exp=0", req_ready); else n_pass++;
    w0 = wr_cnt;
    @(negedge clk);
    init_start = 1'b0; req_valid = 1'b0;
    n_total++; if ({mem_we, mem_wdata, mem_addr, hit_valid} !== {1'b1, 1'b1, 10'd0, 1'b0})
      $display("FAIL prio_init got=%b/%b/%0d/%b exp=1/1/0/0", mem_we, mem_wdata, mem_addr, hit_valid); else n_pass++;
    repeat (40) @(negedge clk);
    n_total++; if (mem_addr !== 10'd40) $display("FAIL init_cnt40 got=%0d exp=40", mem_addr); else n_pass++;
    resetn = 1'b0;
    #1;
    n_total++; if ({mem_we, mem_addr, score, bricks_left, all_clear, req_ready} !== {1'b0, 10'd0, 16'd0, 10'd0, 1'b1, 1'b0})
      $display("FAIL midinit_reset got=%b/%0d/%0d/%0d/%b/%b exp=0/0/0/0/1/0",
               mem_we, mem_addr, score, bricks_left, all_clear, req_ready); else n_pass++;
    w1 = wr_cnt;
    repeat (3) @(negedge clk);
    n_total++; if (wr_cnt != w1 || w1 - w0 != 40)
      $display("FAIL midinit_writes got=%0d/%0d exp=40/0", w1 - w0, wr_cnt - w1); else n_pass++;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back_all_clear;
    logic rdy, wd; int lat, wc; logic [9:0] wa; int bad;
    bad = 0;
    test_fill;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 16; c++) begin
        do_query(10'(c * 8 + 5), 10'(r * 4 + 2), rdy, lat, wc, wa, wd);
        if (rdy !== 1'b1 || lat != 4 || hit !== 1'b1 || hit_x !== 10'(c * 8) || hit_y !== 10'(r * 4)
            || wa !== 10'(c + r * 16)) bad++;
        if (r == 7 && c == 14) begin
          n_total++; if (all_clear !== 1'b0 || bricks_left !== 10'd1)
            $display("FAIL pre_last got=%b/%0d exp=0/1", all_clear, bricks_left); else n_pass++;
        end
        if (!(r == 7 && c == 15)) @(negedge clk);
      end
    end
    n_total++; if (bad != 0) $display("FAIL sweep got=%0d bad queries exp=0", bad); else n_pass++;
    n_total++; if ({score, bricks_left, all_clear} !== {16'd128, 10'd0, 1'b1})
      $display("FAIL all_clear got=%0d/%0d/%b exp=128/0/1", score, bricks_left, all_clear); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 1'b0;
    test_reset;
    test_fill;
    test_hit;
    test_miss;
    test_out_of_grid;
    test_init_priority_and_reset;
    test_back_to_back_all_clear;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
